fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, reset, which is asynchronous and active-high.
REQ-002 Parameter PC_WIDTH, default 8, SHALL set the program counter and memory address width.
REQ-003 Parameter MEM_TIMEOUT, default 15, SHALL set the maximum number of cycles in FETCH without mem_ack (range 1..255).
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  async active-high reset.
REQ-006 Port mem_req  output  1  instruction memory read request.
REQ-007 Port mem_addr  output  PC_WIDTH  read address, always equal to pc.
REQ-008 Port mem_ack  input  1  memory data valid, sampled only while mem_req=1.
REQ-009 Port mem_data  input  8  instruction byte, valid with mem_ack.
REQ-010 Port instruction  output  8  latched instruction byte driven to the IR.
REQ-011 Port LoadIR  output  1  one-cycle IR load strobe.
REQ-012 Port exec_done  input  1  Controller indication that the current instruction has completed.
REQ-013 Port branch_taken  input  1  replace pc+1 with branch_target, sampled only with exec_done.
REQ-014 Port branch_target  input  PC_WIDTH  next pc on a taken branch.
REQ-015 Port halt  input  1  stop fetching after the current instruction.
REQ-016 Port pc  output  PC_WIDTH  current program counter.
REQ-017 Port fetch_error  output  1  sticky memory timeout flag.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, LOAD, EXEC, HALTED and ERROR.
REQ-019 From IDLE: halt=1 -> HALTED, otherwise -> FETCH on the next edge.
REQ-020 In FETCH: mem_req=1 and mem_addr=pc, held stable until mem_ack; on mem_ack, instruction<=mem_data and the FSM -> LOAD.
REQ-021 In LOAD: LoadIR=1 for exactly one cycle, then -> EXEC; ack in cycle n gives LoadIR in cycle n+1.
REQ-022 In EXEC: the FSM waits for exec_done; on exec_done, pc<=branch_taken ? branch_target : pc+1 (mod 2^PC_WIDTH), then -> HALTED if halt=1, else -> FETCH.
REQ-023 pc wrap-around SHALL be silent: pc=2^PC_WIDTH-1 with no branch -> 0.
REQ-024 exec_done and branch_taken SHALL be ignored outside EXEC; halt SHALL be ignored in FETCH and LOAD, so an in-flight fetch always completes.
REQ-025 HALTED and ERROR SHALL be terminal until reset; mem_req=0 and LoadIR=0 in both.
REQ-026 instruction SHALL change only on an accepted mem_ack and otherwise hold its value.

Reset
REQ-027 Assertion of reset SHALL immediately force: state IDLE, pc=0, mem_req=0, LoadIR=0, instruction=8'h00, fetch_error=0, timeout counter=0.
REQ-028 Reset during FETCH SHALL abandon the request; a mem_ack arriving while reset is asserted or in IDLE SHALL be ignored.

Configuration
REQ-029 With macro FETCH_TIMEOUT_EN defined, a counter SHALL run in FETCH (cleared on entry); if MEM_TIMEOUT cycles elapse with no mem_ack, the FSM -> ERROR and fetch_error<=1 (sticky).
REQ-030 Without FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely, the counter SHALL be omitted, fetch_error SHALL be tied 0, and ERROR SHALL be unreachable.

Verification
REQ-031 Reset, then ack after 2 cycles with mem_data=8'hA5 -> mem_addr=0, LoadIR pulse one cycle after ack, instruction=8'hA5, state EXEC.
REQ-032 Three instructions, each with exec_done and no branch -> mem_addr sequence 0,1,2, one LoadIR per instruction.
REQ-033 exec_done with branch_taken=1 and branch_target=8'h40 -> next mem_addr=8'h40; pc=8'hFF with no branch -> next mem_addr=8'h00.
REQ-034 halt=1 asserted during FETCH -> fetch completes, LoadIR pulses, and after exec_done the FSM enters HALTED with mem_req held 0 for 20 cycles.
REQ-035 With FETCH_TIMEOUT_EN and MEM_TIMEOUT=15, no ack -> fetch_error=1 after 15 FETCH cycles and stays 1 until reset; without the macro, same stimulus -> mem_req stays 1 and fetch_error=0.
REQ-036 Reset asserted mid-FETCH with mem_ack arriving in the same cycle -> instruction=8'h00 and pc=0, with no LoadIR pulse.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> FETCH -> LOAD -> EXEC loop with halt and branch handling.
// Optional memory timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [7:0]          mem_data,
  output logic [7:0]          instruction,
  output logic                LoadIR,
  input  logic                exec_done,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("fetch_sequencer: MEM_TIMEOUT must be in 1..255");
  end

  logic [2:0] state;
  logic [2:0] next_state;
  logic       timeout_hit;

  assign mem_addr = pc;

  // Next-state decode; halt is only consulted when leaving IDLE or completing EXEC
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (halt) next_state = HALTED;
        else      next_state = FETCH;
      end
      FETCH: begin
        if (mem_ack)          next_state = LOAD;
        else if (timeout_hit) next_state = ERROR;
        else                  next_state = FETCH;
      end
      LOAD: next_state = EXEC;
      EXEC: begin
        if (exec_done) begin
          if (halt) next_state = HALTED;
          else      next_state = FETCH;
        end else begin
          next_state = EXEC;
        end
      end
      HALTED:  next_state = HALTED;
      ERROR:   next_state = ERROR;
      default: next_state = IDLE;
    endcase
  end

  // State, pc, latched instruction and registered strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= {PC_WIDTH{1'b0}};
      instruction <= 8'h00;
      mem_req     <= 1'b0;
      LoadIR      <= 1'b0;
    end else begin
      state   <= next_state;
      mem_req <= (next_state == FETCH);
      LoadIR  <= (next_state == LOAD);
      if (state == FETCH && mem_ack) begin
        instruction <= mem_data;
      end else begin
        instruction <= instruction;
      end
      if (state == EXEC && exec_done) begin
        pc <= branch_taken ? branch_target : pc + PC_WIDTH'(1);
      end else begin
        pc <= pc;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] timeout_cnt;
  logic       error_flag;

  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
  assign fetch_error = error_flag;

  // Counts unacknowledged FETCH cycles; held at zero outside FETCH so every entry starts fresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_cnt <= 8'd0;
      error_flag  <= 1'b0;
    end else begin
      if (state == FETCH && !mem_ack) begin
        timeout_cnt <= timeout_cnt + 8'd1;
      end else begin
        timeout_cnt <= 8'd0;
      end
      if (state == FETCH && next_state == ERROR) begin
        error_flag <= 1'b1;
      end else begin
        error_flag <= error_flag;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: driver pushes expected fetches, LoadIR monitor pops and checks.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic [7:0] instruction;
  logic       LoadIR;
  logic       exec_done;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       halt;
  logic [7:0] pc;
  logic       fetch_error;

  fetch_sequencer #(.PC_WIDTH(8), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instruction(instruction),
    .LoadIR(LoadIR), .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .pc(pc), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         stamp;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_img[256];
  logic [7:0] model_pc;
  logic [7:0] last_data;
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every LoadIR pulse must match the oldest accepted fetch
  always @(negedge clk) begin
    if (!reset && LoadIR === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_loadir", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ir_data", {24'd0, instruction}, {24'd0, e.data});
        chk("ir_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        chk("ir_latency", cyc, e.stamp);
      end
    end
  end

  task automatic fetch_one(input int delay);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_addr", {24'd0, mem_addr}, {24'd0, model_pc});
    for (int i = 0; i < delay; i++) begin
      exec_done    = 1'($urandom);
      branch_taken = 1'($urandom);
      @(negedge clk);
      chk("fetch_hold", {23'd0, mem_req, mem_addr}, {23'd0, 1'b1, model_pc});
    end
    exec_done = 1'b0;
    mem_ack   = 1'b1;
    mem_data  = mem_img[model_pc];
    last_data = mem_img[model_pc];
    sb.push_back('{addr: model_pc, data: mem_img[model_pc], stamp: cyc + 1});
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_data = 8'($urandom);
  endtask

  task automatic exec_one(input int delay, input logic br, input logic [7:0] tgt);
    @(negedge clk);
    chk("exec_state", {22'd0, mem_req, LoadIR, instruction}, {22'd0, 2'b00, last_data});
    for (int i = 0; i < delay; i++) @(negedge clk);
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    model_pc      = br ? tgt : model_pc + 8'd1;
    @(negedge clk);
    exec_done     = 1'b0;
    branch_taken  = 1'($urandom);
    branch_target = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_data = 8'h00; exec_done = 1'b0;
    branch_taken = 1'b0; branch_target = 8'h00; halt = 1'b0;
    for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
    mem_img[0] = 8'hA5;
    model_pc = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {13'd0, mem_req, LoadIR, fetch_error, pc, instruction}, 32'd0);
    reset = 1'b0;

    // First fetch: ack after 2 cycles with A5, then three sequential instructions
    fetch_one(2);
    exec_one(1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      fetch_one(k);
      exec_one(k, 1'b0, 8'h00);
    end

    // Randomized run with occasional branches
    for (int k = 0; k < 40; k++) begin
      fetch_one($urandom_range(0, 3));
      exec_one($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    // Branch to 0x40, then to 0xFF and wrap to 0x00
    fetch_one(0);
    exec_one(0, 1'b1, 8'h40);
    fetch_one(1);
    exec_one(0, 1'b1, 8'hFF);
    fetch_one(1);
    exec_one(0, 1'b0, 8'h00);
    fetch_one(0);
    exec_one(0, 1'b0, 8'h00);

    // Reset mid-FETCH with a simultaneous ack
    chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_data = 8'h3C; reset = 1'b1;
    #1;
    chk("async_reset", {14'd0, mem_req, LoadIR, pc, instruction}, 32'd0);
    @(negedge clk);
    chk("reset_ack_ignored", {24'd0, instruction}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_ignored", {14'd0, mem_req, LoadIR, pc, instruction}, {14'd0, 2'b10, 16'd0});
    model_pc = 8'h00;

    // Halt raised during FETCH: fetch completes, then HALTED after exec_done
    halt = 1'b1;
    fetch_one(1);
    exec_one(0, 1'b0, 8'h00);
    chk("halt_pc", {24'd0, pc}, {24'd0, model_pc});
    for (int i = 0; i < 20; i++) begin
      chk("halted_idle", {30'd0, mem_req, LoadIR}, 32'd0);
      @(negedge clk);
    end
    halt = 1'b0;

    // Memory never answers
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("to_fetch_entry", {30'd0, mem_req, fetch_error}, {30'd0, 2'b10});
`ifdef FETCH_TIMEOUT_EN
    repeat (14) @(negedge clk);
    chk("to_last_fetch", {30'd0, mem_req, fetch_error}, {30'd0, 2'b10});
    @(negedge clk);
    chk("to_error", {30'd0, mem_req, fetch_error}, {30'd0, 2'b01});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("to_sticky", {30'd0, mem_req, fetch_error}, {30'd0, 2'b01});
    end
    reset = 1'b1;
    #1;
    chk("to_reset_clear", {31'd0, fetch_error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`else
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("no_timeout_wait", {30'd0, mem_req, fetch_error}, {30'd0, 2'b10});
    end
`endif
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
